// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler: state encoding, tag layout, clog2.
package alu_sched_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } sched_state_e;

    // Requester id sits in the low bits of the tag; valid is the MSB.
    localparam int unsigned TAG_ID_LSB = 0;

    function automatic int unsigned tag_valid_pos(input int unsigned databits);
        return databits - 1;
    endfunction

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant
);

    logic [PW-1:0] idx;
    logic          found;

    // N is a power of two, so PW-bit wraparound implements the modulo.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ptr + PW'(k);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler feeding a shared fixed-latency ALU; tags route results back to requesters.
module alu_rr_sched
    import alu_sched_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DATABITS = 4,
    parameter int unsigned MAX_OUT  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*WIDTH-1:0]         req_a,
    input  logic [NREQ*WIDTH-1:0]         req_b,
    input  logic [NREQ*2-1:0]             req_op,
    output logic [NREQ-1:0]               req_ready,
    input  logic                          drain,
    output logic [WIDTH-1:0]              alu_a,
    output logic [WIDTH-1:0]              alu_b,
    output logic [1:0]                    alu_op,
    output logic [DATABITS-1:0]           alu_in_databits,
    input  logic [WIDTH-1:0]              alu_res,
    input  logic [1:0]                    alu_out_op,
    input  logic [DATABITS-1:0]           alu_out_databits,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [WIDTH-1:0]              rsp_res,
    output logic [1:0]                    rsp_op,
    output logic [clog2(MAX_OUT+1)-1:0]   inflight,
    output logic                          idle
);

    localparam int unsigned IDW = clog2(NREQ);
    localparam int unsigned CW  = clog2(MAX_OUT + 1);
    localparam int unsigned VB  = tag_valid_pos(DATABITS);

    sched_state_e          state_q;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [WIDTH-1:0]      a_q, a_d, b_q, b_d;
    logic [1:0]            op_q, op_d;
    logic [DATABITS-1:0]   tag_q, tag_d;

    logic [NREQ-1:0]       grant;
    logic                  pick_en;
    logic                  hs;
    logic [IDW-1:0]        gid;
    logic                  ret_valid;
    logic [IDW-1:0]        ret_id;
    logic                  unused_tag;

    assign pick_en = (state_q == ST_RUN) && (inflight_q < CW'(MAX_OUT)) && !reset;

    rr_pick #(
        .N  (NREQ),
        .PW (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .en    (pick_en),
        .grant (grant)
    );

    assign req_ready  = grant;
    assign ret_valid  = alu_out_databits[VB];
    assign ret_id     = alu_out_databits[TAG_ID_LSB +: IDW];
    assign unused_tag = ^alu_out_databits;

    // Issue path: encode the grant, mux the winning operands, build the tag.
    always_comb begin
        hs         = |(req_valid & grant);
        gid        = '0;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        tag_d      = '0;
        ptr_d      = ptr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gid  = IDW'(i);
                a_d  = req_a[i*WIDTH +: WIDTH];
                b_d  = req_b[i*WIDTH +: WIDTH];
                op_d = req_op[i*2 +: 2];
            end
        end
        if (hs) begin
            tag_d[VB]                 = 1'b1;
            tag_d[TAG_ID_LSB +: IDW]  = gid;
            ptr_d                     = gid + IDW'(1);
        end
    end

    // A handshake and a return in the same cycle cancel out.
    always_comb begin
        inflight_d = inflight_q;
        if (hs && !ret_valid) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!hs && ret_valid && (inflight_q != '0)) begin
            inflight_d = inflight_q - CW'(1);
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rsp_valid[i] = ret_valid && (ret_id == IDW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            ptr_q      <= '0;
            inflight_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tag_q      <= '0;
        end else begin
            state_q    <= drain ? ST_DRAIN : ST_RUN;
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
        end
    end

    assign alu_a           = a_q;
    assign alu_b           = b_q;
    assign alu_op          = op_q;
    assign alu_in_databits = tag_q;
    assign rsp_res         = alu_res;
    assign rsp_op          = alu_out_op;
    assign inflight        = inflight_q;
    assign idle            = (inflight_q == '0) && !tag_q[VB];

endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched with a 3-stage ALU stub; a second instance exercises the in-flight cap.
module tb_alu_rr_sched;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DB    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*WIDTH-1:0]  req_a, req_b;
    logic [NREQ*2-1:0]      req_op;
    logic [NREQ-1:0]        req_ready;
    logic                   drain;
    logic [WIDTH-1:0]       alu_a, alu_b;
    logic [1:0]             alu_op;
    logic [DB-1:0]          alu_in_databits;
    logic [WIDTH-1:0]       alu_res;
    logic [1:0]             alu_out_op;
    logic [DB-1:0]          alu_out_databits;
    logic [NREQ-1:0]        rsp_valid;
    logic [WIDTH-1:0]       rsp_res;
    logic [1:0]             rsp_op;
    logic [3:0]             inflight;
    logic                   idle;

    // Second instance: MAX_OUT=2, ALU never returns a valid tag.
    logic [NREQ-1:0]        rv2, r2_ready;
    logic [DB-1:0]          r2_tag;
    logic [1:0]             r2_inflight;
    logic [WIDTH-1:0]       r2_unused_a, r2_unused_b, r2_unused_res;
    logic [1:0]             r2_unused_op, r2_unused_rop;
    logic [NREQ-1:0]        r2_unused_rv;
    logic                   r2_unused_idle;

    alu_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DATABITS(DB), .MAX_OUT(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .req_ready(req_ready), .drain(drain), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_in_databits(alu_in_databits), .alu_res(alu_res),
        .alu_out_op(alu_out_op), .alu_out_databits(alu_out_databits), .rsp_valid(rsp_valid),
        .rsp_res(rsp_res), .rsp_op(rsp_op), .inflight(inflight), .idle(idle)
    );

    alu_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DATABITS(DB), .MAX_OUT(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(rv2), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .req_ready(r2_ready), .drain(drain), .alu_a(r2_unused_a),
        .alu_b(r2_unused_b), .alu_op(r2_unused_op), .alu_in_databits(r2_tag),
        .alu_res('0), .alu_out_op(2'b00), .alu_out_databits(4'b0000),
        .rsp_valid(r2_unused_rv), .rsp_res(r2_unused_res), .rsp_op(r2_unused_rop),
        .inflight(r2_inflight), .idle(r2_unused_idle)
    );

    // ALU stub: three register stages, shares reset with the scheduler.
    logic [WIDTH-1:0] s1_a, s1_b, s2_a, s2_b;
    logic [1:0]       s1_op, s2_op;
    logic [DB-1:0]    s1_tag, s2_tag;
    always @(posedge clk) begin
        if (reset) begin
            s1_a <= '0; s1_b <= '0; s1_op <= '0; s1_tag <= '0;
            s2_a <= '0; s2_b <= '0; s2_op <= '0; s2_tag <= '0;
            alu_res <= '0; alu_out_op <= '0; alu_out_databits <= '0;
        end else begin
            s1_a <= alu_a; s1_b <= alu_b; s1_op <= alu_op; s1_tag <= alu_in_databits;
            s2_a <= s1_a;  s2_b <= s1_b;  s2_op <= s1_op;  s2_tag <= s1_tag;
            case (s2_op)
                2'd0:    alu_res <= s2_a + s2_b;
                2'd1:    alu_res <= s2_a - s2_b;
                2'd2:    alu_res <= s2_a & s2_b;
                default: alu_res <= s2_a | s2_b;
            endcase
            alu_out_op       <= s2_op;
            alu_out_databits <= s2_tag;
        end
    end

    typedef struct { logic [DB-1:0] tag; logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; logic [1:0] op; } iss_t;
    typedef struct { logic [NREQ-1:0] vec; logic [WIDTH-1:0] res; logic [1:0] op; } rsp_t;
    iss_t iss_q[$];
    rsp_t rsp_q[$];

    int n_chk = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    logic [WIDTH-1:0] ta [NREQ];
    logic [WIDTH-1:0] tb_v [NREQ];
    logic [1:0]       top_v [NREQ];
    logic [WIDTH-1:0] tres [NREQ];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic load_table;
        for (int i = 0; i < int'(NREQ); i++) begin
            req_a[i*WIDTH +: WIDTH] = ta[i];
            req_b[i*WIDTH +: WIDTH] = tb_v[i];
            req_op[i*2 +: 2]        = top_v[i];
        end
    endtask

    task automatic expect_op(input int i);
        iss_t e;
        rsp_t r;
        e.tag = DB'(8 + i);
        e.a   = ta[i];
        e.b   = tb_v[i];
        e.op  = top_v[i];
        r.vec = NREQ'(1 << i);
        r.res = tres[i];
        r.op  = top_v[i];
        iss_q.push_back(e);
        rsp_q.push_back(r);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic wait_idle;
        int c;
        c = 0;
        while (!idle && c < 100) begin
            tick;
            c++;
        end
        chk("idle_wait", 64'(idle), 64'd1);
    endtask

    // Monitor: every issued tag and every returned response is popped and compared.
    always @(negedge clk) begin
        if (mon_en) begin
            if (alu_in_databits[DB-1]) begin
                if (iss_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_issue: got tag %0h expected none", alu_in_databits);
                end else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    chk("issue_tag", 64'(alu_in_databits), 64'(e.tag));
                    chk("issue_a",   64'(alu_a),  64'(e.a));
                    chk("issue_b",   64'(alu_b),  64'(e.b));
                    chk("issue_op",  64'(alu_op), 64'(e.op));
                end
            end
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_rsp: got rsp_valid %0h expected none", rsp_valid);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(r.vec));
                    chk("rsp_res",   64'(rsp_res),   64'(r.res));
                    chk("rsp_op",    64'(rsp_op),    64'(r.op));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] inf_exp [8];
        inf_exp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
        ta    = '{32'd20, 32'd21, 32'd22, 32'd23};
        tb_v  = '{32'd6,  32'd7,  32'd8,  32'd9};
        top_v = '{2'd0,   2'd1,   2'd2,   2'd3};
        tres  = '{32'd26, 32'd14, 32'd0,  32'd31};
        req_valid = '0; rv2 = '0; drain = 1'b0;
        load_table;
        do_reset;
        mon_en = 1'b1;

        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_idle",     64'(idle), 64'd1);
        chk("rst_tag",      64'(alu_in_databits), 64'd0);
        chk("rst_a",        64'(alu_a), 64'd0);
        chk("rst_op",       64'(alu_op), 64'd0);

        // Continuous requests: rotating grants; inflight saturates at 4 where issue and return overlap.
        for (int k = 0; k < 8; k++) expect_op(k % 4);
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1 chk("rr_ready", 64'(req_ready), 64'(1 << (k % 4)));
            tick;
            chk("rr_inflight", 64'(inflight), 64'(inf_exp[k]));
        end
        req_valid = '0;
        wait_idle;

        // Single ADD from requester 0, checked at the exact return cycle.
        ta[0] = 32'd5; tb_v[0] = 32'd3; tres[0] = 32'd8;
        load_table;
        expect_op(0);
        req_valid = 4'b0001;
        #1 chk("add_ready", 64'(req_ready), 64'd1);
        tick;
        req_valid = '0;
        chk("add_tag", 64'(alu_in_databits), 64'd8);
        chk("add_inflight1", 64'(inflight), 64'd1);
        tick;
        chk("add_norsp1", 64'(rsp_valid), 64'd0);
        tick;
        chk("add_norsp2", 64'(rsp_valid), 64'd0);
        tick;
        chk("add_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("add_rsp_res", 64'(rsp_res), 64'd8);
        chk("add_inflight_ret", 64'(inflight), 64'd1);
        tick;
        chk("add_inflight0", 64'(inflight), 64'd0);
        chk("add_idle", 64'(idle), 64'd1);
        ta[0] = 32'd20; tb_v[0] = 32'd6; tres[0] = 32'd26;
        load_table;

        // Drain with three ops outstanding.
        do_reset;
        for (int k = 0; k < 3; k++) expect_op(k);
        req_valid = 4'hF;
        #1 chk("drn_ready0", 64'(req_ready), 64'd1);
        tick;
        chk("drn_inflight1", 64'(inflight), 64'd1);
        #1 chk("drn_ready1", 64'(req_ready), 64'd2);
        tick;
        drain = 1'b1;
        #1 chk("drn_ready2", 64'(req_ready), 64'd4);
        tick;
        chk("drn_inflight3", 64'(inflight), 64'd3);
        for (int j = 0; j < 4; j++) begin
            #1 chk("drn_no_grant", 64'(req_ready), 64'd0);
            tick;
            chk("drn_inflight", 64'(inflight), 64'(3 - (j > 0 ? j : 0)));
            chk("drn_idle", 64'(idle), 64'(j == 3));
        end
        drain = 1'b0;
        req_valid = '0;
        tick;

        // Reset mid-flight discards outstanding ops.
        do_reset;
        for (int k = 0; k < 3; k++) expect_op(k);
        for (int k = 0; k < 3; k++) rsp_q.pop_back();
        req_valid = 4'hF;
        tick; tick; tick;
        chk("mrst_inflight3", 64'(inflight), 64'd3);
        reset = 1'b1;
        #1 chk("mrst_ready_in_reset", 64'(req_ready), 64'd0);
        tick;
        reset = 1'b0;
        chk("mrst_inflight0", 64'(inflight), 64'd0);
        chk("mrst_idle", 64'(idle), 64'd1);
        chk("mrst_tag", 64'(alu_in_databits), 64'd0);
        #1 chk("mrst_ptr0", 64'(req_ready), 64'd1);
        req_valid = '0;
        for (int j = 0; j < 6; j++) begin
            tick;
            chk("mrst_no_rsp", 64'(rsp_valid), 64'd0);
        end

        // In-flight cap on the MAX_OUT=2 instance.
        do_reset;
        rv2 = 4'hF;
        #1 chk("cap_ready0", 64'(r2_ready), 64'd1);
        tick;
        chk("cap_inflight1", 64'(r2_inflight), 64'd1);
        chk("cap_tag0", 64'(r2_tag), 64'd8);
        #1 chk("cap_ready1", 64'(r2_ready), 64'd2);
        tick;
        chk("cap_inflight2", 64'(r2_inflight), 64'd2);
        chk("cap_tag1", 64'(r2_tag), 64'd9);
        #1 chk("cap_ready_blocked", 64'(r2_ready), 64'd0);
        tick;
        chk("cap_inflight_hold", 64'(r2_inflight), 64'd2);
        chk("cap_tag_none", 64'(r2_tag), 64'd0);
        chk("cap_ready_still", 64'(r2_ready), 64'd0);
        rv2 = '0;

        tick; tick;
        chk("iss_q_empty", 64'(iss_q.size()), 64'd0);
        chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_rr_sched.md
ALU_RR_SCHED -- requirements
Module: alu_rr_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters (power of 2, 2..8).
REQ-002 SHALL have parameter WIDTH, default 32: operand/result width.
REQ-003 SHALL have parameter DATABITS, default 4: ALU tag width; DATABITS >= 1+clog2(NREQ).
REQ-004 SHALL have parameter MAX_OUT, default 8: in-flight op limit.
REQ-005 SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have the ports req_valid (input, NREQ), req_a and req_b (input, NREQ*WIDTH) and req_op (input, NREQ*2): packed per-requester requests; requester i occupies slice i.
REQ-008 SHALL have the port req_ready, output, NREQ: grant, one-hot or zero.
REQ-009 SHALL have the port drain, input, 1 bit: stop issuing new ops.
REQ-010 SHALL have the ports alu_a and alu_b (output, WIDTH), alu_op (output, 2) and alu_in_databits (output, DATABITS): drive the ALU a, b, in_op and in_databits inputs.
REQ-011 SHALL have the ports alu_res (input, WIDTH), alu_out_op (input, 2) and alu_out_databits (input, DATABITS): ALU outputs.
REQ-012 SHALL have the ports rsp_valid (output, NREQ), rsp_res (output, WIDTH) and rsp_op (output, 2): result return.
REQ-013 SHALL have the ports inflight (output, clog2(MAX_OUT+1)) and idle (output, 1): status.

Function
REQ-014 SHALL format the tag as bit DATABITS-1 = valid and bits clog2(NREQ)-1:0 = requester id, with the remaining bits 0.
REQ-015 SHALL have two states, RUN and DRAIN: RUN->DRAIN when drain=1, DRAIN->RUN when drain=0, each evaluated every cycle.
REQ-016 SHALL grant (RUN only, inflight<MAX_OUT) the first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NREQ; req_ready is combinational from req_valid, ptr, state and inflight.
REQ-017 SHALL grant nothing in DRAIN or when inflight==MAX_OUT; a same-cycle response does not lift the cap.
REQ-018 SHALL count a handshake when req_valid[i] and req_ready[i] are both 1, and then set ptr to (i+1) mod NREQ; ptr is unchanged with no handshake.
REQ-019 SHALL register the granted a/b/op into alu_a/alu_b/alu_op and {1,id} into alu_in_databits on the next edge, giving 1-cycle issue latency.
REQ-020 SHALL, in a cycle with no handshake, load alu_in_databits=0 and hold alu_a/alu_b/alu_op.
REQ-021 SHALL decode rsp_valid[i] = alu_out_databits[DATABITS-1] AND id==i, combinationally, with 0-cycle return latency.
REQ-022 SHALL pass rsp_res = alu_res and rsp_op = alu_out_op unregistered; responses have no backpressure and requesters must accept them.
REQ-023 SHALL update inflight as +1 on handshake, -1 on a valid returned tag, unchanged when both occur; it never exceeds MAX_OUT and never underflows.
REQ-024 SHALL drive idle = (inflight==0) AND (alu_in_databits valid bit==0).
REQ-025 SHALL keep requester order in order: results return in issue order per requester because the ALU pipeline is fixed-latency.

Reset
REQ-026 SHALL, with reset=1 at an edge, set: state=RUN, ptr=0, inflight=0, alu_in_databits=0, alu_a=alu_b=0, alu_op=0.
REQ-027 SHALL force req_ready=0 while reset=1.
REQ-028 SHALL, on reset mid-operation, discard ops in flight; the ALU shares reset, so no stale tag returns afterwards.

Structure
REQ-029 SHALL place the tag field positions, the RUN/DRAIN state encoding and a clog2 function in a shared package alu_sched_pkg.
REQ-030 SHALL implement the round-robin search as one sub-module, rr_pick (inputs req, ptr, en; output one-hot grant); all else stays in alu_rr_sched.

Verification
REQ-031 SHALL cover: reset, then req_valid=4'b1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3, with alu_in_databits = 8,9,10,11,8,... one cycle after each grant.
REQ-032 SHALL cover: req0 a=5, b=3, op=ADD -> rsp_valid=4'b0001 with rsp_res=8 exactly when the ALU returns tag 8, and inflight returning to 0.
REQ-033 SHALL cover: MAX_OUT=2 with the ALU output tags forced invalid and continuous requests -> exactly 2 grants, then req_ready=0 and inflight=2.
REQ-034 SHALL cover: drain=1 while 3 ops are in flight -> no grants, inflight 3->0 as results return, and idle=1 one cycle after the last one.
REQ-035 SHALL cover: a handshake and a response in the same cycle -> inflight unchanged.
REQ-036 SHALL cover: reset asserted with inflight=3 -> next cycle inflight=0, ptr=0, idle=1, and no rsp_valid afterwards.
